maze_memory: RTL and testbench

//   Maze storage that sits directly below the intelligent rat. It answers
//   the rat's cell reads (RD/X/Y -> D_out) and records its visited-cell

---
 rtl/maze_memory_if.sv | 33 +++
 rtl/maze_memory.sv | 109 ++++++++++
 tb/tb_maze_memory.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/maze_memory_if.sv
// Rat/loader-facing bus of the maze memory.
// The master drives requests and the slave (the memory) answers them.
interface maze_memory_if #(
    parameter int N = 4
);
    localparam int W = 1 << N;

    logic         start_load;
    logic         load_valid;
    logic [W-1:0] load_row;
    logic         load_ready;
    logic         load_done;
    logic         restore;
    logic         mem_ready;
    logic         RD;
    logic         WR;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic         D_in;
    logic         D_out;

    modport master (
        output start_load, load_valid, load_row, restore,
        output RD, WR, X, Y, D_in,
        input  load_ready, load_done, mem_ready, D_out
    );

    modport slave (
        input  start_load, load_valid, load_row, restore,
        input  RD, WR, X, Y, D_in,
        output load_ready, load_done, mem_ready, D_out
    );
endinterface

// File: rtl/maze_memory.sv
// Two-bank maze store: row-serial load, rat read/write on the working
// bank, and row-per-cycle restore of the working bank from the original.
module maze_memory #(
    parameter int N = 4
) (
    input logic          clk,
    input logic          rst,
    maze_memory_if.slave bus
);
    localparam int W = 1 << N;

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_READY   = 2'd2;
    localparam logic [1:0] S_RESTORE = 2'd3;

    localparam logic [N-1:0] LAST_ROW = '1;

    logic [1:0]   state_q,     state_d;
    logic [N-1:0] row_cnt_q,   row_cnt_d;
    logic         d_out_q,     d_out_d;
    logic         load_done_q, load_done_d;

    logic [W-1:0] orig_q [W];
    logic [W-1:0] orig_d [W];
    logic [W-1:0] work_q [W];
    logic [W-1:0] work_d [W];

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        d_out_d     = d_out_q;
        load_done_d = 1'b0;
        orig_d      = orig_q;
        work_d      = work_q;

        // A new load restarts from row 0 whatever else is requested.
        if (bus.start_load) begin
            state_d   = S_LOAD;
            row_cnt_d = '0;
        end else begin
            unique case (1'b1)
                (state_q == S_LOAD): begin
                    if (bus.load_valid) begin
                        orig_d[row_cnt_q] = bus.load_row;
                        work_d[row_cnt_q] = bus.load_row;
                        if (row_cnt_q == LAST_ROW) begin
                            state_d     = S_READY;
                            row_cnt_d   = '0;
                            load_done_d = 1'b1;
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end
                end
                (state_q == S_READY): begin
                    if (bus.restore) begin
                        state_d   = S_RESTORE;
                        row_cnt_d = '0;
                    end else begin
                        // Read samples the old bank, so RD+WR is read-first.
                        if (bus.RD) begin
                            d_out_d = work_q[bus.Y][bus.X];
                        end
                        if (bus.WR) begin
                            work_d[bus.Y][bus.X] = bus.D_in;
                        end
                    end
                end
                (state_q == S_RESTORE): begin
                    work_d[row_cnt_q] = orig_q[row_cnt_q];
                    if (row_cnt_q == LAST_ROW) begin
                        state_d   = S_READY;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_EMPTY;
            row_cnt_q   <= '0;
            d_out_q     <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            d_out_q     <= d_out_d;
            load_done_q <= load_done_d;
        end
    end

    always_ff @(posedge clk) begin
        orig_q <= orig_d;
        work_q <= work_d;
    end

    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.mem_ready  = (state_q == S_READY);
    assign bus.load_done  = load_done_q;
    assign bus.D_out      = d_out_q;
endmodule

// File: tb/tb_maze_memory.sv
// Directed bench for maze_memory: reference bank model plus a queue of
// expected read data popped when D_out is produced.
module tb_maze_memory;
    localparam int N = 4;
    localparam int W = 1 << N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [W-1:0] m_orig [W];
    logic [W-1:0] m_work [W];
    logic         exp_q [$];

    maze_memory_if #(.N(N)) bus ();

    maze_memory #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int x, input int y, input string tag);
        logic e;
        bus.RD = 1'b1;
        bus.X  = x[N-1:0];
        bus.Y  = y[N-1:0];
        exp_q.push_back(m_work[y][x]);
        tick();
        bus.RD = 1'b0;
        e = exp_q.pop_front();
        check(tag, bus.D_out, e);
    endtask

    task automatic wr(input int x, input int y, input logic d);
        bus.WR   = 1'b1;
        bus.X    = x[N-1:0];
        bus.Y    = y[N-1:0];
        bus.D_in = d;
        m_work[y][x] = d;
        tick();
        bus.WR = 1'b0;
    endtask

    task automatic load_maze(input int stall_after, input int stall_n,
                             input bit inv, output int ncyc);
        logic [W-1:0] row;
        ncyc = 0;
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
        check("ld_ready_start", bus.load_ready, 1);
        for (int y = 0; y < W; y++) begin
            row = 16'h0001 << y;
            if (inv) row = ~row;
            bus.load_valid = 1'b1;
            bus.load_row   = row;
            m_orig[y] = row;
            m_work[y] = row;
            tick();
            ncyc++;
            check("ld_done_row", bus.load_done, (y == W - 1));
            check("mem_ready_row", bus.mem_ready, (y == W - 1));
            if (y == stall_after) begin
                bus.load_valid = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    ncyc++;
                    check("stall_ready", bus.load_ready, 1);
                    check("stall_rowcnt", dut.row_cnt_q, y + 1);
                    check("stall_done", bus.load_done, 0);
                end
            end
        end
        bus.load_valid = 1'b0;
        tick();
        check("ld_done_once", bus.load_done, 0);
        check("mem_ready_hold", bus.mem_ready, 1);
    endtask

    initial begin
        int n1;
        int n2;
        int low;
        logic [W-1:0] row;

        bus.start_load = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_row   = '0;
        bus.restore    = 1'b0;
        bus.RD         = 1'b0;
        bus.WR         = 1'b0;
        bus.X          = '0;
        bus.Y          = '0;
        bus.D_in       = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_load_ready", bus.load_ready, 0);
        check("rst_load_done", bus.load_done, 0);
        check("rst_mem_ready", bus.mem_ready, 0);
        check("rst_dout", bus.D_out, 0);
        #2 rst = 1'b1;
        tick();

        // Test 1: plain load
        load_maze(-1, 0, 1'b0, n1);
        check("t1_cycles", n1, 16);

        // Test 3: reads and hold
        rd(3, 3, "t3_rd33");
        rd(4, 3, "t3_rd43");
        rd(3, 3, "t3_rd33b");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold", bus.D_out, 1);
        end
        for (int y = 0; y < W; y += 5) begin
            rd(y, y, "t1_diag");
            rd((y + 1) % W, y, "t1_off");
        end

        // Test 4: read-before-write on the same cell
        bus.WR   = 1'b1;
        bus.D_in = 1'b1;
        rd(4, 3, "t4_old");
        bus.WR = 1'b0;
        m_work[3][4] = 1'b1;
        rd(4, 3, "t4_new");

        // Test 5: write then restore
        wr(4, 3, 1'b1);
        bus.restore = 1'b1;
        bus.RD = 1'b1;
        bus.X  = 4'd5;
        bus.Y  = 4'd3;
        tick();
        bus.restore = 1'b0;
        check("t5_rd_same_cycle", bus.D_out, 1);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_ready) break;
            low++;
            tick();
            bus.RD = 1'b0;
            check("t5_dout_hold", bus.D_out, 1);
        end
        check("t5_low_cycles", low, 16);
        for (int y = 0; y < W; y++) m_work[y] = m_orig[y];
        rd(4, 3, "t5_restored");
        rd(3, 3, "t5_diag");

        // Test 2: load with a 3-cycle stall after row 5
        load_maze(5, 3, 1'b0, n2);
        check("t2_delay", n2 - n1, 3);
        rd(6, 6, "t2_diag6");
        rd(7, 6, "t2_off6");
        rd(15, 15, "t2_diag15");

        // Test 6: restart mid-load with an inverted maze
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
        for (int y = 0; y < 8; y++) begin
            row = 16'h0001 << y;
            bus.load_valid = 1'b1;
            bus.load_row   = row;
            tick();
            check("t6_no_done", bus.load_done, 0);
        end
        bus.load_valid = 1'b0;
        load_maze(-1, 0, 1'b1, n1);
        for (int y = 0; y < W; y += 3) begin
            rd(y, y, "t6_diag");
            rd((y + 1) % W, y, "t6_off");
        end
        rd(1, 0, "t6_pre_rst");

        // Reset during restore
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        tick();
        tick();
        check("t6_in_restore", bus.mem_ready, 0);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_mem_ready", bus.mem_ready, 0);
        check("t6_rst_dout", bus.D_out, 0);
        check("t6_rst_state", dut.state_q, 0);
        tick();
        #2 rst = 1'b1;
        bus.RD = 1'b1;
        bus.X  = 4'd1;
        bus.Y  = 4'd0;
        tick();
        bus.RD = 1'b0;
        check("empty_rd_ignored", bus.D_out, 0);
        check("empty_load_ready", bus.load_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
